// File: rtl/video_capture.sv
// Parallel video receiver: checks line/frame geometry, locks on a good
// frame and streams tagged 24-bit pixels through a show-ahead FIFO.
module video_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [35:0]                 vid_data,
    input  logic                        vid_hsync,
    input  logic                        vid_vsync,
    input  logic                        vid_en,
    output logic [23:0]                 out_data,
    output logic [$clog2(H_ACTIVE)-1:0] out_x,
    output logic [$clog2(V_ACTIVE)-1:0] out_y,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        locked,
    output logic                        err,
    output logic [7:0]                  err_cnt,
    output logic                        ovf
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 2);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [PW-1:0] H_END  = PW'(H_ACTIVE);
    localparam logic [PW-1:0] H_LAST = PW'(H_ACTIVE - 1);
    localparam logic [PW-1:0] H_SAT  = PW'(H_ACTIVE + 1);
    localparam logic [LW-1:0] V_END  = LW'(V_ACTIVE);
    localparam logic [LW-1:0] V_SAT  = LW'(V_ACTIVE + 1);
    localparam logic [AW:0]   P_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [23:0]   data;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
        logic          eol;
    } pix_t;

    logic [23:0] d_r;
    logic        hs_r, hs_q, vs_r, vs_q, en_r;
    logic        hs_fall, vs_fall;
    logic        vid_unused;

    assign vid_unused = ^{vid_data[27:24], vid_data[15:12], vid_data[3:0]};

    // sync samples idle high so reset release never looks like a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r  <= '0;
            hs_r <= 1'b1;
            hs_q <= 1'b1;
            vs_r <= 1'b1;
            vs_q <= 1'b1;
            en_r <= 1'b0;
        end else begin
            d_r  <= {vid_data[35:28], vid_data[23:16], vid_data[11:4]};
            hs_r <= vid_hsync;
            hs_q <= hs_r;
            vs_r <= vid_vsync;
            vs_q <= vs_r;
            en_r <= vid_en;
        end
    end

    assign hs_fall = hs_q & ~hs_r;
    assign vs_fall = vs_q & ~vs_r;

    logic [PW-1:0] pix_cnt, pc_base, pc_nxt;
    logic [LW-1:0] line_cnt, lc_line, lc_base;
    logic          line_err, frame_err;

    always_comb begin
        line_err = 1'b0;
        lc_line  = line_cnt;
        if (hs_fall && pix_cnt != '0) begin
            if (line_cnt != V_SAT)
                lc_line = line_cnt + LW'(1);
            line_err = (pix_cnt != H_END);
        end
        frame_err = vs_fall && (lc_line != V_END);
        pc_base   = (hs_fall || vs_fall) ? '0 : pix_cnt;
        lc_base   = vs_fall ? '0 : lc_line;
        pc_nxt    = pc_base;
        if (en_r && pc_base != H_SAT)
            pc_nxt = pc_base + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            pix_cnt  <= pc_nxt;
            line_cnt <= lc_base;
        end
    end

    state_t state, state_nxt;
    logic   bad, bad_nxt, err_nxt;

    always_comb begin
        state_nxt = state;
        bad_nxt   = bad;
        err_nxt   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt = ACQUIRE;
                    bad_nxt   = 1'b0;
                end
            end
            ACQUIRE: begin
                if (line_err)
                    bad_nxt = 1'b1;
                if (vs_fall) begin
                    if (!bad_nxt && lc_line == V_END)
                        state_nxt = LOCKED;
                    bad_nxt = 1'b0;
                end
            end
            LOCKED: begin
                if (line_err || frame_err) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_req, wr_en, ovf_nxt;
    pix_t        wr_pix, head;
    pix_t        mem [FIFO_DEPTH];

    assign push_req = (state == LOCKED) && !line_err && !frame_err && en_r
                      && (pc_base < H_END) && (lc_base < V_END);

    assign wr_pix.data = d_r;
    assign wr_pix.x    = pc_base[XW-1:0];
    assign wr_pix.y    = lc_base[YW-1:0];
    assign wr_pix.sof  = (pc_base == '0) && (lc_base == '0);
    assign wr_pix.eol  = (pc_base == H_LAST);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                     && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && out_ready;
    assign wr_en   = push_req && (!full || pop);
    assign ovf_nxt = push_req && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            bad     <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            ovf     <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state <= state_nxt;
            bad   <= bad_nxt;
            err   <= err_nxt;
            ovf   <= ovf_nxt;
            if (err_nxt && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (wr_en)
                wr_ptr <= wr_ptr + P_ONE;
            if (pop)
                rd_ptr <= rd_ptr + P_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= wr_pix;
    end

    assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign out_data  = head.data;
    assign out_x     = head.x;
    assign out_y     = head.y;
    assign out_sof   = head.sof;
    assign out_eol   = head.eol;
    assign out_valid = !empty;
    assign locked    = (state == LOCKED);

endmodule

// File: tb/tb_video_capture.sv
// Directed frame sequences with random pixel data and gaps, scored
// against a line-level model of the capture rules.
module tb_video_capture;

    localparam int H = 8;
    localparam int V = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [35:0] vid_data;
    logic        vid_hsync, vid_vsync, vid_en;
    logic [23:0] out_data;
    logic [2:0]  out_x;
    logic [1:0]  out_y;
    logic        out_sof, out_eol, out_valid, out_ready;
    logic        locked, err, ovf;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_data(vid_data), .vid_hsync(vid_hsync),
        .vid_vsync(vid_vsync), .vid_en(vid_en),
        .out_data(out_data), .out_x(out_x), .out_y(out_y),
        .out_sof(out_sof), .out_eol(out_eol),
        .out_valid(out_valid), .out_ready(out_ready),
        .locked(locked), .err(err), .err_cnt(err_cnt), .ovf(ovf)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int m_state = 0;   // 0 search, 1 acquire, 2 locked
    int m_lines = 0;
    int m_pix = 0;
    bit m_bad = 1'b0;
    int m_errs = 0;
    int m_errcnt = 0;
    int m_ovf = 0;
    int err_pulses = 0;
    int ovf_pulses = 0;
    int pops = 0;
    int gap_lo = 1;
    int gap_hi = 1;
    logic [30:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pack(input logic [35:0] d);
        return {d[35:28], d[23:16], d[11:4]};
    endfunction

    task automatic tick();
        logic [30:0] got;
        @(negedge clk);
        if (out_valid && out_ready) begin
            pops++;
            got = {out_data, out_x, out_y, out_sof, out_eol};
            chk("exp_avail", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0)
                chk("pixel", 64'(got), 64'(exp_q.pop_front()));
        end
        if (err) err_pulses++;
        if (ovf) ovf_pulses++;
        @(posedge clk);
        #1;
    endtask

    task automatic model_boundary(input bit vs, output bit exp_err);
        bit le, fe;
        exp_err = 1'b0;
        le = 1'b0;
        if (m_pix != 0) begin
            if (m_lines < V + 1) m_lines++;
            le = (m_pix != H);
        end
        fe = vs && (m_lines != V);
        case (m_state)
            0: if (vs) begin m_state = 1; m_bad = 1'b0; end
            1: begin
                if (le) m_bad = 1'b1;
                if (vs) begin
                    if (!m_bad && m_lines == V) m_state = 2;
                    m_bad = 1'b0;
                end
            end
            default: if (le || fe) begin
                m_state = 0;
                exp_err = 1'b1;
                m_errs++;
                if (m_errcnt < 255) m_errcnt++;
            end
        endcase
        if (vs) m_lines = 0;
        m_pix = 0;
    endtask

    task automatic send_line(input int n, input bit vs,
                             input bit special, input bit stall);
        bit was_locked, e_err;
        logic [35:0] d;
        int gap;
        was_locked = (m_state == 2);
        model_boundary(vs, e_err);
        vid_hsync = 1'b0;
        vid_vsync = !vs;
        vid_en = 1'b0;
        tick();
        chk("locked_hold", 64'(locked), 64'(was_locked));
        tick();
        chk("locked_edge", 64'(locked), 64'(m_state == 2));
        chk("err_pulse", 64'(err), 64'(e_err));
        vid_hsync = 1'b1;
        vid_vsync = 1'b1;
        tick();
        chk("err_single", 64'(err), 64'(0));
        tick();
        chk("locked", 64'(locked), 64'(m_state == 2));
        chk("err_cnt", 64'(err_cnt), 64'(m_errcnt));
        chk("err_pulses", 64'(err_pulses), 64'(m_errs));
        chk("ovf_pulses", 64'(ovf_pulses), 64'(m_ovf));
        if (stall) out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = {4'($urandom), $urandom};
            if (special && i == 0) d = 36'hABCDEF123;
            if (m_state == 2 && i < H && m_lines < V) begin
                if (stall && i >= D)
                    m_ovf++;
                else
                    exp_q.push_back({((special && i == 0) ? 24'hABDE12
                                      : pack(d)),
                                     3'(i), 2'(m_lines),
                                     (i == 0 && m_lines == 0),
                                     (i == H - 1)});
            end
            vid_data = d;
            vid_en = 1'b1;
            tick();
            vid_en = 1'b0;
            gap = $urandom_range(gap_hi, gap_lo);
            repeat (gap) tick();
        end
        m_pix = n;
        tick();
        tick();
        out_ready = 1'b1;
    endtask

    task automatic send_frame(input int nact, input int short_idx,
                              input int special_idx, input int stall_idx);
        send_line(0, 1'b1, 1'b0, 1'b0);
        send_line(0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < nact; k++)
            send_line((k == short_idx) ? H - 1 : H, 1'b0,
                      k == special_idx, k == stall_idx);
    endtask

    initial begin
        int p0;
        bit e_dummy;
        rst_n = 1'b0;
        vid_data = '0;
        vid_hsync = 1'b1;
        vid_vsync = 1'b1;
        vid_en = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_locked", 64'(locked), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_xy", 64'({out_x, out_y, out_sof, out_eol}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // clean frames, 1-of-2 enable gaps
        send_frame(V, -1, -1, -1);
        p0 = pops;
        send_frame(V, -1, -1, -1);
        repeat (4) tick();
        chk("frame_pixels", 64'(pops - p0), 64'(V * H));
        send_frame(V, -1, -1, -1);

        gap_lo = 0;
        gap_hi = 2;
        send_frame(V, -1, 0, -1);
        // short line, then recovery
        send_frame(V, 1, -1, -1);
        send_frame(V, -1, -1, -1);
        send_frame(V, -1, -1, -1);
        // five active lines, then recovery
        send_frame(V + 1, -1, -1, -1);
        send_frame(V, -1, -1, -1);
        send_frame(V, -1, -1, -1);
        send_frame(V, -1, -1, -1);
        // consumer stall across one line
        send_frame(V, -1, -1, 1);
        send_frame(V, -1, -1, -1);
        chk("ovf_total", 64'(ovf_pulses), 64'(4));

        // reset mid-line with pixels queued
        send_line(0, 1'b1, 1'b0, 1'b0);
        send_line(0, 1'b0, 1'b0, 1'b0);
        model_boundary(1'b0, e_dummy);
        vid_hsync = 1'b0;
        tick();
        tick();
        vid_hsync = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        repeat (3) begin
            vid_data = {4'($urandom), $urandom};
            vid_en = 1'b1;
            tick();
        end
        vid_en = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'(m_state == 2));
        chk("pre_rst_locked", 64'(locked), 64'(m_state == 2));
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_locked", 64'(locked), 64'(0));
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'(0));
        m_state = 0;
        m_lines = 0;
        m_pix = 0;
        m_bad = 1'b0;
        m_errcnt = 0;
        exp_q.delete();
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(V, -1, -1, -1);
        send_frame(V, -1, -1, -1);
        send_frame(V, -1, -1, -1);

        repeat (10) tick();
        chk("drained", 64'(exp_q.size()), 64'(0));
        chk("final_err_cnt", 64'(err_cnt), 64'(m_errcnt));
        chk("final_locked", 64'(locked), 64'(m_state == 2));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
